// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store unit for a MIPS-style pipeline.
// Big-endian byte lanes, synchronous data RAM with combinational reads,
// address-error detection and a three-state IDLE/ACCESS/DONE handshake.
// Optional LL/SC link-bit support is enabled by defining LSU_LLSC_EN; without
// it LL behaves as LW and SC behaves as SW that always reports success.
module lsu_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    input  logic        flush,
    input  logic        llbit_clr,
    output logic        ram_ce,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [3:0]  ram_sel,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_wen,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic [31:0] badvaddr
);

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Opcodes 10..15 are illegal and complete silently.
    function automatic logic is_legal(input logic [3:0] o);
        is_legal = (o <= OP_SC);
    endfunction

    // Stores, including SC, raise AdES rather than AdEL.
    function automatic logic is_store_op(input logic [3:0] o);
        case (o)
            OP_SB, OP_SH, OP_SW, OP_SC: is_store_op = 1'b1;
            default:                    is_store_op = 1'b0;
        endcase
    endfunction

    // Everything that writes the register file: loads, LL and SC.
    function automatic logic writes_reg(input logic [3:0] o);
        case (o)
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL, OP_SC: writes_reg = 1'b1;
            default:                                           writes_reg = 1'b0;
        endcase
    endfunction

    // Natural alignment check; byte accesses and illegal ops never fault.
    function automatic logic misaligned(input logic [3:0] o, input logic [1:0] off);
        case (o)
            OP_LH, OP_LHU, OP_SH:       misaligned = off[0];
            OP_LW, OP_SW, OP_LL, OP_SC: misaligned = (off != 2'd0);
            default:                    misaligned = 1'b0;
        endcase
    endfunction

    // Big-endian lane select: offset 0 is the most significant byte.
    function automatic logic [3:0] lane_sel(input logic [3:0] o, input logic [1:0] off);
        case (o)
            OP_LB, OP_LBU, OP_SB:       lane_sel = 4'b1000 >> off;
            OP_LH, OP_LHU, OP_SH:       lane_sel = off[1] ? 4'b0011 : 4'b1100;
            OP_LW, OP_SW, OP_LL, OP_SC: lane_sel = 4'b1111;
            default:                    lane_sel = 4'b0000;
        endcase
    endfunction

    // Store data replicated across all lanes; ram_sel picks the live ones.
    function automatic logic [31:0] store_data(input logic [3:0] o, input logic [31:0] wd);
        case (o)
            OP_SB:        store_data = {4{wd[7:0]}};
            OP_SH:        store_data = {2{wd[15:0]}};
            OP_SW, OP_SC: store_data = wd;
            default:      store_data = 32'h0000_0000;
        endcase
    endfunction

    // Extract and extend the addressed byte/halfword from a big-endian word.
    function automatic logic [31:0] load_data(input logic [3:0] o, input logic [1:0] off,
                                              input logic [31:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        case (off)
            2'd0:    b = d[31:24];
            2'd1:    b = d[23:16];
            2'd2:    b = d[15:8];
            default: b = d[7:0];
        endcase
        h = off[1] ? d[15:0] : d[31:16];
        case (o)
            OP_LB:        load_data = {{24{b[7]}}, b};
            OP_LBU:       load_data = {24'h00_0000, b};
            OP_LH:        load_data = {{16{h[15]}}, h};
            OP_LHU:       load_data = {16'h0000, h};
            OP_LW, OP_LL: load_data = d;
            default:      load_data = 32'h0000_0000;
        endcase
    endfunction

    state_t      state_q, state_d;
    logic [3:0]  op_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [4:0]  rd_q;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_wen_q, resp_wen_d;
    logic        exc_adel_q, exc_adel_d;
    logic        exc_ades_q, exc_ades_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        sc_ok_s;
    logic        access_live_s;
    logic        early_done_s;

    // A request that faults or is illegal skips the RAM cycle entirely.
    assign early_done_s  = misaligned(op, addr[1:0]) || !is_legal(op);
    // The RAM cycle is live only in ACCESS and only if not cancelled.
    assign access_live_s = (state_q == ST_ACCESS) && !flush;

`ifdef LSU_LLSC_EN
    logic llbit_q, llbit_d;

    // Link bit state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            llbit_q <= 1'b0;
        end else begin
            llbit_q <= llbit_d;
        end
    end

    // Link bit update: an external clear beats a completing LL.
    always_comb begin
        llbit_d = llbit_q;
        if (llbit_clr) begin
            llbit_d = 1'b0;
        end else if (access_live_s && (op_q == OP_LL)) begin
            llbit_d = 1'b1;
        end else if (access_live_s && (op_q == OP_SC)) begin
            llbit_d = 1'b0;
        end else begin
            llbit_d = llbit_q;
        end
    end

    assign sc_ok_s = llbit_q;
`else
    logic unused_llbit_clr_s;

    // Without link tracking every SC succeeds and the clear input is ignored.
    assign sc_ok_s            = 1'b1;
    assign unused_llbit_clr_s = llbit_clr;
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: flush always wins and drops any pending response.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (req_valid) begin
                    state_d = early_done_s ? ST_DONE : ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (flush || resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Capture the request on acceptance so inputs may change afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q    <= 4'd0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rd_q    <= 5'd0;
        end else if ((state_q == ST_IDLE) && req_valid && !flush) begin
            op_q    <= op;
            addr_q  <= addr;
            wdata_q <= wdata;
            rd_q    <= rd;
        end
    end

    // Response next state: built on entry to DONE, held in DONE, cleared in IDLE.
    always_comb begin
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        resp_wen_d  = resp_wen_q;
        exc_adel_d  = exc_adel_q;
        exc_ades_d  = exc_ades_q;
        badvaddr_d  = badvaddr_q;
        if (state_d == ST_IDLE) begin
            resp_data_d = 32'h0000_0000;
            resp_rd_d   = 5'd0;
            resp_wen_d  = 1'b0;
            exc_adel_d  = 1'b0;
            exc_ades_d  = 1'b0;
            badvaddr_d  = 32'h0000_0000;
        end else if ((state_q == ST_IDLE) && (state_d == ST_DONE)) begin
            resp_data_d = 32'h0000_0000;
            resp_rd_d   = rd;
            resp_wen_d  = 1'b0;
            exc_adel_d  = misaligned(op, addr[1:0]) && !is_store_op(op);
            exc_ades_d  = misaligned(op, addr[1:0]) && is_store_op(op);
            badvaddr_d  = misaligned(op, addr[1:0]) ? addr : 32'h0000_0000;
        end else if ((state_q == ST_ACCESS) && (state_d == ST_DONE)) begin
            resp_rd_d   = rd_q;
            resp_wen_d  = writes_reg(op_q);
            exc_adel_d  = 1'b0;
            exc_ades_d  = 1'b0;
            badvaddr_d  = 32'h0000_0000;
            if (op_q == OP_SC) begin
                resp_data_d = {31'h0000_0000, sc_ok_s};
            end else begin
                resp_data_d = load_data(op_q, addr_q[1:0], ram_rdata);
            end
        end else begin
            resp_data_d = resp_data_q;
        end
    end

    // Response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_data_q <= 32'h0000_0000;
            resp_rd_q   <= 5'd0;
            resp_wen_q  <= 1'b0;
            exc_adel_q  <= 1'b0;
            exc_ades_q  <= 1'b0;
            badvaddr_q  <= 32'h0000_0000;
        end else begin
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
            resp_wen_q  <= resp_wen_d;
            exc_adel_q  <= exc_adel_d;
            exc_ades_q  <= exc_ades_d;
            badvaddr_q  <= badvaddr_d;
        end
    end

    // RAM drive: decoded from the state register so reset kills a write at once.
    always_comb begin
        ram_ce    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = 32'h0000_0000;
        ram_sel   = 4'b0000;
        ram_wdata = 32'h0000_0000;
        if (access_live_s) begin
            ram_ce    = 1'b1;
            ram_we    = is_store_op(op_q) && ((op_q != OP_SC) || sc_ok_s);
            ram_addr  = addr_q;
            ram_sel   = lane_sel(op_q, addr_q[1:0]);
            ram_wdata = store_data(op_q, wdata_q);
        end else begin
            ram_ce    = 1'b0;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_DONE);
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_wen   = resp_wen_q;
    assign exc_adel   = exc_adel_q;
    assign exc_ades   = exc_ades_q;
    assign badvaddr   = badvaddr_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed testbench for lsu_stage with a small word-addressed RAM model.
module tb_lsu_stage;

    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_SB  = 4'd5;
    localparam logic [3:0] OP_SH  = 4'd6;
    localparam logic [3:0] OP_SW  = 4'd7;
    localparam logic [3:0] OP_LL  = 4'd8;
    localparam logic [3:0] OP_SC  = 4'd9;

    logic        clk, rst;
    logic        req_valid, req_ready;
    logic [3:0]  op;
    logic [31:0] addr, wdata;
    logic [4:0]  rd;
    logic        flush, llbit_clr;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic [3:0]  ram_sel;
    logic        resp_valid, resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_wen, exc_adel, exc_ades;
    logic [31:0] badvaddr;

    logic [31:0] mem [0:63];

    int          tests_run;
    int          tests_failed;
    int          lat_s;
    logic [3:0]  sel_seen_s;
    logic        ce_seen_s;
    logic        we_seen_s;
    logic        seen_s;

    lsu_stage dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .rd         (rd),
        .flush      (flush),
        .llbit_clr  (llbit_clr),
        .ram_ce     (ram_ce),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_sel    (ram_sel),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_rd    (resp_rd),
        .resp_wen   (resp_wen),
        .exc_adel   (exc_adel),
        .exc_ades   (exc_ades),
        .badvaddr   (badvaddr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: cleared and preloaded under reset, lane-masked synchronous writes.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'h0000_0000;
            mem[16] <= 32'h80FF_0000;
        end else if (ram_ce && ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_sel[b]) mem[ram_addr[7:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
    end
    assign ram_rdata = mem[ram_addr[7:2]];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Issue one request, then watch RAM activity until resp_valid or timeout.
    task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] r, input logic rr);
        lat_s = 0; sel_seen_s = 4'h0; ce_seen_s = 1'b0; we_seen_s = 1'b0;
        @(negedge clk);
        op = o; addr = a; wdata = wd; rd = r; resp_ready = rr; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; op = 4'hE; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF; rd = 5'd31;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (ram_ce) begin
                ce_seen_s  = 1'b1;
                sel_seen_s = ram_sel;
                if (ram_we) we_seen_s = 1'b1;
            end
            if (resp_valid) begin
                lat_s = i;
                break;
            end
        end
    endtask

    task automatic expect_resp(input string tag, input int lat, input logic [31:0] data,
                               input logic wen, input logic adel, input logic ades);
        check({tag, "_lat"},  lat_s, lat);
        check({tag, "_data"}, resp_data, data);
        check({tag, "_wen"},  resp_wen, {31'h0, wen});
        check({tag, "_exc"},  {exc_adel, exc_ades}, {30'h0, adel, ades});
    endtask

    initial begin
        tests_run = 0; tests_failed = 0;
        rst = 1'b1; req_valid = 1'b0; op = 4'd0; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
        flush = 1'b0; llbit_clr = 1'b0; resp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_flags", {resp_valid, ram_ce, ram_we, resp_wen, exc_adel, exc_ades}, 32'h0);
        check("rst_ready", req_ready, 32'h1);
        check("rst_data", resp_data, 32'h0);
        check("rst_badv", badvaddr, 32'h0);
        rst = 1'b0;

        // Halfword loads from the preloaded word 0x80FF0000.
        run_op(OP_LH, 32'h40, 32'h0, 5'd2, 1'b1);
        expect_resp("lh40", 2, 32'hFFFF_80FF, 1'b1, 1'b0, 1'b0);
        check("lh40_sel", sel_seen_s, 32'hC);
        check("lh40_rd", resp_rd, 32'd2);
        run_op(OP_LHU, 32'h40, 32'h0, 5'd3, 1'b1);
        expect_resp("lhu40", 2, 32'h0000_80FF, 1'b1, 1'b0, 1'b0);

        // Word store then byte loads with sign and zero extension.
        run_op(OP_SW, 32'h40, 32'h1122_3344, 5'd0, 1'b1);
        expect_resp("sw40", 2, 32'h0, 1'b0, 1'b0, 1'b0);
        check("sw40_sel", sel_seen_s, 32'hF);
        check("sw40_we", we_seen_s, 32'h1);
        check("sw40_mem", mem[16], 32'h1122_3344);
        run_op(OP_LB, 32'h41, 32'h0, 5'd4, 1'b1);
        expect_resp("lb41", 2, 32'h0000_0022, 1'b1, 1'b0, 1'b0);
        check("lb41_sel", sel_seen_s, 32'h4);
        run_op(OP_LBU, 32'h43, 32'h0, 5'd5, 1'b1);
        expect_resp("lbu43", 2, 32'h0000_0044, 1'b1, 1'b0, 1'b0);
        check("lbu43_rd", resp_rd, 32'd5);

        // Sub-word stores land in big-endian lanes.
        run_op(OP_SB, 32'h42, 32'h0000_00A5, 5'd0, 1'b1);
        check("sb42_sel", sel_seen_s, 32'h2);
        check("sb42_mem", mem[16], 32'h1122_A544);
        run_op(OP_LB, 32'h42, 32'h0, 5'd6, 1'b1);
        expect_resp("lb42", 2, 32'hFFFF_FFA5, 1'b1, 1'b0, 1'b0);
        run_op(OP_SH, 32'h40, 32'h0000_BEEF, 5'd0, 1'b1);
        check("sh40_sel", sel_seen_s, 32'hC);
        check("sh40_mem", mem[16], 32'hBEEF_A544);
        run_op(OP_LW, 32'h40, 32'h0, 5'd7, 1'b1);
        expect_resp("lw40", 2, 32'hBEEF_A544, 1'b1, 1'b0, 1'b0);

        // Address errors and illegal opcodes skip the RAM.
        run_op(OP_LW, 32'h42, 32'h0, 5'd8, 1'b1);
        expect_resp("lw42", 1, 32'h0, 1'b0, 1'b1, 1'b0);
        check("lw42_badv", badvaddr, 32'h42);
        check("lw42_ce", ce_seen_s, 32'h0);
        run_op(OP_SH, 32'h41, 32'h1234, 5'd9, 1'b1);
        expect_resp("sh41", 1, 32'h0, 1'b0, 1'b0, 1'b1);
        check("sh41_badv", badvaddr, 32'h41);
        check("sh41_ce", ce_seen_s, 32'h0);
        run_op(4'd12, 32'h40, 32'h0, 5'd10, 1'b1);
        expect_resp("ill12", 1, 32'h0, 1'b0, 1'b0, 1'b0);
        check("ill12_ce", ce_seen_s, 32'h0);

        // Backpressure holds the response stable.
        run_op(OP_LW, 32'h40, 32'h0, 5'd11, 1'b0);
        check("bp_lat", lat_s, 32'd2);
        repeat (3) begin
            @(negedge clk);
            check("bp_valid", resp_valid, 32'h1);
            check("bp_data", resp_data, 32'hBEEF_A544);
            check("bp_rd", resp_rd, 32'd11);
            check("bp_ready", req_ready, 32'h0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release", {resp_valid, req_ready}, 32'h1);

        // Flush during ACCESS cancels the store.
        @(negedge clk);
        op = OP_SW; addr = 32'h48; wdata = 32'hDEAD_BEEF; rd = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b1;
        #1;
        check("flush_ram", {ram_ce, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_idle", req_ready, 32'h1);
        seen_s = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (resp_valid) seen_s = 1'b1;
        end
        check("flush_noresp", seen_s, 32'h0);
        check("flush_mem", mem[18], 32'h0);

        // Flush beats a simultaneous acceptance.
        @(negedge clk);
        op = OP_LW; addr = 32'h40; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0; flush = 1'b0;
        check("flushpri_ready", req_ready, 32'h1);
        check("flushpri_ce", ram_ce, 32'h0);

        // LL / SC.
        run_op(OP_LL, 32'h80, 32'h0, 5'd12, 1'b1);
        expect_resp("ll80", 2, 32'h0, 1'b1, 1'b0, 1'b0);
        run_op(OP_SC, 32'h80, 32'h1234_5678, 5'd13, 1'b1);
        expect_resp("sc80", 2, 32'h1, 1'b1, 1'b0, 1'b0);
        check("sc80_we", we_seen_s, 32'h1);
        check("sc80_mem", mem[32], 32'h1234_5678);
        run_op(OP_LL, 32'h80, 32'h0, 5'd14, 1'b1);
        expect_resp("ll80b", 2, 32'h1234_5678, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        llbit_clr = 1'b1;
        @(negedge clk);
        llbit_clr = 1'b0;
        run_op(OP_SC, 32'h80, 32'h0000_0009, 5'd15, 1'b1);
`ifdef LSU_LLSC_EN
        expect_resp("sc_clr", 2, 32'h0, 1'b1, 1'b0, 1'b0);
        check("sc_clr_we", we_seen_s, 32'h0);
        check("sc_clr_mem", mem[32], 32'h1234_5678);
`else
        expect_resp("sc_noll", 2, 32'h1, 1'b1, 1'b0, 1'b0);
        check("sc_noll_we", we_seen_s, 32'h1);
        check("sc_noll_mem", mem[32], 32'h0000_0009);
`endif
        run_op(OP_SC, 32'h82, 32'h0, 5'd16, 1'b1);
        expect_resp("sc82", 1, 32'h0, 1'b0, 1'b0, 1'b1);
        check("sc82_badv", badvaddr, 32'h82);

        // Reset in the middle of ACCESS drops the write immediately.
        @(negedge clk);
        op = OP_SW; addr = 32'h4C; wdata = 32'h55; rd = 5'd0; req_valid = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check("rstmid_pre_we", ram_we, 32'h1);
        rst = 1'b1;
        #1;
        check("rstmid_ram", {ram_ce, ram_we}, 32'h0);
        check("rstmid_valid", resp_valid, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_idle", {req_ready, resp_valid}, 32'h2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/lsu_stage.md
LSU_STAGE -- requirements
Module: lsu_stage

Interface
REQ-001 SHALL have port clk, input, 1: sole clock, all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-003 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake from the EX/MEM register.
REQ-004 SHALL have ports op (input, 4), addr (input, 32), wdata (input, 32) and rd (input, 5): access opcode, byte address, store data and destination register.
REQ-005 SHALL have ports flush (input, 1) and llbit_clr (input, 1): pipeline cancel and ERET link-bit clear.
REQ-006 SHALL have data-RAM ports ram_ce, ram_we (output, 1 each), ram_addr (output, 32), ram_sel (output, 4), ram_wdata (output, 32) and ram_rdata (input, 32); RAM reads are combinational and writes are synchronous.
REQ-007 SHALL have response ports resp_valid (output, 1), resp_ready (input, 1), resp_data (output, 32), resp_rd (output, 5) and resp_wen (output, 1).
REQ-008 SHALL have exception ports exc_adel, exc_ades (output, 1 each) and badvaddr (output, 32).

Function
REQ-009 SHALL implement opcodes 0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; codes 10-15 SHALL complete with no RAM access, resp_wen=0 and no exception.
REQ-010 SHALL use states IDLE, ACCESS and DONE; req_ready=1 only in IDLE.
REQ-011 SHALL register the request on req_valid&&req_ready in IDLE, then go to ACCESS, or go to DONE directly if the access is misaligned or the opcode is illegal.
REQ-012 SHALL assert ram_ce=1 only in ACCESS with flush=0; ram_we=1 only for stores (and for SC only when the SC succeeds); every RAM output SHALL be 0 outside ACCESS.
REQ-013 SHALL drive ram_addr equal to the registered address and use big-endian lanes: byte offset 0 maps to sel 4'b1000 / bits 31:24, and offset 3 maps to sel 4'b0001 / bits 7:0.
REQ-014 SHALL use sel 1100 for halfword offset 0 and 0011 for offset 2, and sel 1111 for words; store data SHALL be replicated into the selected lanes.
REQ-015 SHALL capture load data from ram_rdata at the end of ACCESS; LB and LH SHALL sign-extend, and LBU and LHU SHALL zero-extend.
REQ-016 SHALL give a latency of exactly 2 cycles from acceptance to resp_valid when resp_ready is held high; resp_valid SHALL be 1 only in DONE.
REQ-017 SHALL hold DONE and all resp_* outputs stable while resp_ready=0, and return to IDLE on resp_ready=1.
REQ-018 SHALL set resp_wen=1 for loads, LL and SC, and 0 for stores and exceptions.
REQ-019 SHALL treat halfword addresses with addr[0]=1, and word, LL and SC addresses with addr[1:0]!=0, as misaligned.
REQ-020 SHALL report a misaligned load with exc_adel=1 and a misaligned store or SC with exc_ades=1, with badvaddr=addr, all valid in DONE.
REQ-021 SHALL return the FSM to IDLE on the next edge when flush=1 in any state, with no response.
REQ-022 SHALL give flush priority over a simultaneous request acceptance.

Reset
REQ-023 SHALL, while rst=1, force state IDLE, llbit=0, resp_valid=0, resp_data=0, resp_rd=0, resp_wen=0, exc_adel=0, exc_ades=0, badvaddr=0 and all RAM outputs 0.
REQ-024 SHALL, on reset asserted mid-ACCESS, suppress the write immediately (asynchronous).

Configuration
REQ-025 SHALL, with LSU_LLSC_EN defined, keep a 1-bit llbit: LL completion sets it, and a completed SC or llbit_clr clears it.
REQ-026 SHALL give llbit_clr priority over a simultaneous LL set.
REQ-027 SHALL, with LSU_LLSC_EN defined, make SC with llbit=1 write and return resp_data=1, and SC with llbit=0 not write and return resp_data=0.
REQ-028 SHALL, without LSU_LLSC_EN, execute LL as LW and SC as SW returning resp_data=1, with no llbit storage and llbit_clr ignored.

Verification
REQ-029 SHALL verify: SW 0x11223344 to 0x40, then LB at 0x41 and LBU at 0x43, gives sel=1111, then resp_data 0x00000022 and 0x00000044.
REQ-030 SHALL verify: memory word 0x80FF0000, LH at 0x40 gives 0xFFFF80FF and LHU gives 0x000080FF.
REQ-031 SHALL verify: LW at 0x42 gives exc_adel=1, badvaddr=0x42, ram_ce=0 in every cycle and resp_wen=0.
REQ-032 SHALL verify: resp_ready held 0 for 3 cycles keeps resp_valid=1 and resp_data unchanged, and req_ready=0.
REQ-033 SHALL verify with LSU_LLSC_EN: LL 0x80, then SC 0x80, gives resp_data=1 and memory updated; LL, llbit_clr, then SC gives resp_data=0 and no write.
REQ-034 SHALL verify: SW accepted, then flush in the ACCESS cycle, gives ram_we=0, no response and memory unchanged.
